// File: rtl/mux_seq_pkg.sv
// Shared widths, state encodings and scan-direction constants for the mux scan sequencer.
package mux_seq_pkg;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/prio_enc8.sv
// Combinational priority encoder: index of the lowest (dir=0) or highest (dir=1) set request bit.
module prio_enc8
  import mux_seq_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic             dir,
  output logic [SEL_W-1:0] idx,
  output logic             any_set
);

  // Later matches overwrite earlier ones, so loop order picks the winning end.
  always_comb begin
    idx     = '0;
    any_set = |req;
    if (dir == DIR_ASC) begin
      for (int i = int'(N_CH) - 1; i >= 0; i--) begin
        if (req[i]) idx = SEL_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (req[i]) idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the 8:1 mux select lines over the enabled channels and streams the returned bit
// on a valid/ready handshake, pulsing done once per scan.
module mux_scan_sequencer
  import mux_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic             dir,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_y,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic [SEL_W-1:0] cur_ch,
  output logic             busy,
  output logic             done
);

  state_t            state_q, state_d;
  logic [N_CH-1:0]   pending_q, pending_d;
  logic              dir_q, dir_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [N_CH-1:0]   pending_clr;
  logic [N_CH-1:0]   enc_req;
  logic              enc_dir;
  logic [SEL_W-1:0]  enc_idx;
  logic              enc_any;

  // One encoder serves both the first-channel pick (from ch_mask) and the next-channel pick.
  always_comb begin
    pending_clr = pending_q & ~(N_CH'(1) << sel_q);
    if (state_q == ST_IDLE) begin
      enc_req = ch_mask;
      enc_dir = dir;
    end else begin
      enc_req = pending_clr;
      enc_dir = dir_q;
    end
  end

  prio_enc8 u_prio_enc8 (
    .req     (enc_req),
    .dir     (enc_dir),
    .idx     (enc_idx),
    .any_set (enc_any)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    dir_d     = dir_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          if (enc_any) begin
            pending_d = ch_mask;
            dir_d     = dir;
            sel_d     = enc_idx;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            state_d   = ST_SCAN;
          end else begin
            done_d  = 1'b1;
            state_d = ST_FIN;
          end
        end
      end

      ST_SCAN: begin
        if (valid_q && bit_ready) begin
          pending_d = pending_clr;
          if (enc_any) begin
            sel_d = enc_idx;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end
        end
      end

      ST_FIN: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        pending_d = '0;
        sel_d     = '0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      dir_q     <= DIR_ASC;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // bit_out is the mux return gated by valid; no added latency on the data path.
  assign bit_out   = mux_y & valid_q;
  assign bit_valid = valid_q;
  assign mux_sel   = sel_q;
  assign cur_ch    = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer with a behavioural 8:1 mux on the return path.
module tb_mux_scan_sequencer;
  import mux_seq_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [N_CH-1:0]  ch_mask;
  logic             dir;
  logic [SEL_W-1:0] mux_sel;
  logic             mux_y;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic [SEL_W-1:0] cur_ch;
  logic             busy;
  logic             done;

  logic [N_CH-1:0]  mux_data;
  logic [SEL_W:0]   exp_q[$];
  int               total = 0;
  int               bad   = 0;

  always #5 clk = ~clk;

  assign mux_y = mux_data[mux_sel];

  mux_scan_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ch_mask   (ch_mask),
    .dir       (dir),
    .mux_sel   (mux_sel),
    .mux_y     (mux_y),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .cur_ch    (cur_ch),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mux_sel"},   32'(mux_sel),   0);
    check({tag, "_cur_ch"},    32'(cur_ch),    0);
    check({tag, "_bit_valid"}, 32'(bit_valid), 0);
    check({tag, "_bit_out"},   32'(bit_out),   0);
    check({tag, "_busy"},      32'(busy),      0);
    check({tag, "_done"},      32'(done),      0);
  endtask

  // Runs one scan from IDLE. stall_n ready-low cycles are applied while channel stall_ch is
  // presented; a stray start with a different mask is injected at loop cycle ign_cyc.
  task automatic run_scan(input logic [N_CH-1:0] mask, input logic d, input logic [N_CH-1:0] data,
                          input int stall_ch, input int stall_n, input int ign_cyc);
    int n       = 0;
    int vcnt    = 0;
    int bcnt    = 0;
    int done_at = -1;
    int stalls  = stall_n;
    logic [SEL_W:0] e;

    mux_data = data;
    exp_q.delete();
    for (int k = 0; k < int'(N_CH); k++) begin
      int i;
      i = (d == DIR_DESC) ? int'(N_CH) - 1 - k : k;
      if (mask[i]) begin
        exp_q.push_back({data[i], SEL_W'(i)});
        n++;
      end
    end

    start   = 1'b1;
    ch_mask = mask;
    dir     = d;
    @(posedge clk); #1;
    start   = 1'b0;
    ch_mask = ~mask;
    dir     = ~d;

    for (int c = 0; c < 64 && done_at < 0; c++) begin
      start     = (c == ign_cyc);
      bit_ready = 1'b1;
      if (stalls > 0 && int'(mux_sel) == stall_ch) begin
        bit_ready = 1'b0;
        stalls--;
      end
      @(negedge clk);
      if (bit_valid) vcnt++;
      if (busy) bcnt++;
      if (bit_valid && !bit_ready) check("stall_sel", 32'(mux_sel), 32'(stall_ch));
      if (bit_valid && bit_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_bit", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("mux_sel", 32'(mux_sel), 32'(e[SEL_W-1:0]));
          check("cur_ch",  32'(cur_ch),  32'(e[SEL_W-1:0]));
          check("bit_out", 32'(bit_out), 32'(e[SEL_W]));
        end
      end
      if (done) done_at = c;
      @(posedge clk); #1;
    end
    start = 1'b0;

    check("done_cycle",   32'(done_at), 32'(n + stall_n));
    check("valid_cycles", 32'(vcnt),    32'(n + stall_n));
    check("busy_cycles",  32'(bcnt),    32'(n + stall_n));
    check("sb_leftover",  32'(exp_q.size()), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done),      0);
    check("idle_busy",      32'(busy),      0);
    check("idle_valid",     32'(bit_valid), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    ch_mask   = '0;
    dir       = DIR_ASC;
    bit_ready = 1'b0;
    mux_data  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("por");

    // bit_out must stay gated while nothing is valid
    mux_data = 8'hFF;
    @(negedge clk);
    check("idle_bit_out_gated", 32'(bit_out), 0);
    @(posedge clk); #1;

    run_scan(8'hFF, DIR_ASC,  8'b1010_0110, -1, 0, -1);
    run_scan(8'b0100_1001, DIR_DESC, 8'b0100_0001, -1, 0, -1);
    run_scan(8'h0F, DIR_ASC,  8'b0000_0101, 2, 4, -1);
    run_scan(8'h00, DIR_ASC,  8'hFF, -1, 0, -1);
    run_scan(8'h10, DIR_DESC, 8'h10, -1, 0, -1);
    run_scan(8'hFF, DIR_DESC, 8'b0011_1001, 7, 2, -1);

    // reset after two accepted bits of a full ascending scan
    mux_data  = 8'hFF;
    ch_mask   = 8'hFF;
    dir       = DIR_ASC;
    bit_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_sel", 32'(mux_sel), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("mid_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_done", 32'(done), 0);
      check("post_rst_idle",    32'(busy), 0);
    end
    @(posedge clk); #1;

    // start during SCAN with a different mask and direction must be ignored
    run_scan(8'h3C, DIR_ASC, 8'b0101_0100, -1, 0, 1);

    for (int k = 0; k < 6; k++) begin
      logic [N_CH-1:0] m;
      logic [N_CH-1:0] dt;
      m  = N_CH'($urandom);
      dt = N_CH'($urandom);
      run_scan(m, 1'($urandom), dt, -1, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream control stage for the 8-to-1 multiplexer (MUX8x1_using_4x1_and_2x1_design).
- Drives the mux select lines to walk through a programmable set of enabled channels.
- Takes the mux output back in and presents it as a serial bit stream on a valid/ready handshake.
- Flags completion of each scan with a one-cycle done pulse.

Parameters:
- N_CH, 8: number of mux channels. Fixed at 8 for this mux.
- SEL_W, 3: select width, equal to log2(N_CH).

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request a scan; sampled only in IDLE
- ch_mask  input  8  channel enable mask; bit k enables channel k; sampled with start
- dir  input  1  scan order: 0 = ascending channel index, 1 = descending; sampled with start
- mux_sel  output  SEL_W  select lines to the mux s[2:0]
- mux_y  input  1  mux output y (combinational return path)
- bit_out  output  1  serial data bit, equal to mux_y AND bit_valid
- bit_valid  output  1  bit_out holds the current channel's bit
- bit_ready  input  1  downstream accepts the bit
- cur_ch  output  SEL_W  index of the channel being presented (equals mux_sel)
- busy  output  1  high in SCAN
- done  output  1  one-cycle pulse at the end of each scan

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on any rising edge with rst=1, state goes to IDLE and all outputs return to reset values on the next cycle. Reset values: mux_sel=0, cur_ch=0, bit_valid=0, bit_out=0, busy=0, done=0, pending mask=0. This applies mid-scan too: the partial scan is abandoned and no done pulse is produced.
- States:
  - IDLE (2'b00)
  - SCAN (2'b01)
  - FIN (2'b10)
  - Encoding 2'b11 is illegal and recovers to IDLE.
- IDLE:
  - start=1 and ch_mask!=0: latch pending=ch_mask and dir_q=dir. Load mux_sel with the first enabled channel: lowest set bit if dir=0, highest set bit if dir=1. Go to SCAN.
  - start=1 and ch_mask==0: go to FIN. No bits are emitted.
  - Otherwise: stay in IDLE.
- SCAN:
  - bit_valid=1 and busy=1.
  - bit_out follows mux_y combinationally; the sequencer adds zero latency.
  - mux_sel and bit_valid stay stable until bit_valid & bit_ready.
  - On a handshake, clear pending[mux_sel]:
    - If the remaining pending bits are nonzero, load mux_sel with the next enabled channel in dir_q order and present the new bit next cycle. Back-to-back handshakes give one bit per cycle.
    - If no pending bits remain, go to FIN.
- FIN: done=1 for exactly one cycle, then go to IDLE. start is ignored in FIN.
- start is ignored while in SCAN. ch_mask and dir changes during a scan have no effect.
- Order is strictly index-monotonic; disabled channels are skipped with no idle cycles.
- A single enabled channel gives a one-bit scan.
- Scan length equals popcount(ch_mask). Completion latency = popcount + stall cycles + 1 cycle (FIN).
- bit_ready is don't-care outside SCAN.

Decomposition:
- Shared package mux_seq_pkg holds:
  - N_CH and SEL_W
  - state encodings ST_IDLE, ST_SCAN, ST_FIN
  - a DIR_ASC / DIR_DESC constant pair
- One natural sub-module: prio_enc8.
  - Inputs: 8-bit request and a dir bit.
  - Outputs: 3-bit index of the lowest (dir=0) or highest (dir=1) set bit, plus any_set.
  - Purely combinational.
  - Used for both the first-channel load and the next-channel load.

Test Plan:
- Ascending full scan: ch_mask=8'hFF, dir=0, bit_ready held 1, mux data 8'b1010_0110 → mux_sel sequence 0..7 on consecutive cycles; bit_out 0,1,1,0,0,1,0,1; done pulses 1 cycle after the last bit.
- Sparse descending scan: ch_mask=8'b0100_1001, dir=1 → mux_sel 6,3,0; exactly 3 valid bits, no gap cycles; busy high for 3 cycles.
- Backpressure: ch_mask=8'h0F, bit_ready low for 4 cycles on channel 2 → mux_sel stays 2 and bit_valid stays 1 throughout; channel 3 follows after ready rises; total valid cycles = 8.
- Empty mask: start with ch_mask=0 → bit_valid never rises; done pulses the cycle after start; busy stays 0.
- Reset mid-operation and ignored start: rst=1 for one cycle after 2 accepted bits of an 8'hFF scan → next cycle all outputs at reset values, no done pulse. Then start during SCAN with a different mask → ignored, original order completes.
